commit_unit: RTL

//  In-order retire stage directly downstream of the 32-entry reorder buffer; consumes the ROB head entry.

---
 rtl/commit_if.sv | 47 ++++
 rtl/commit_unit.sv | 97 +++++++++
 2 files changed

// File: rtl/commit_if.sv
// Purpose : bundles the ROB-head, regfile, RAT, store and flush signals of the commit stage.
// Latency : none (wiring only).
// Backpressure: store handshake is st_req_o / st_ack_i; the ROB pops on dequeue_o.
// Modports:
//   master - ROB / memory side: drives the head entry and st_ack_i, and observes the commit outputs.
//   slave  - commit unit: reads the head entry and st_ack_i, and drives the commit outputs.
interface commit_if #(
  parameter int XLEN      = 32,
  parameter int ROB_IDX_W = 5
);
  logic                 head_valid_i;
  logic                 head_done_i;
  logic [XLEN-1:0]      head_pc_i;
  logic [ROB_IDX_W-1:0] head_rob_idx_i;
  logic [4:0]           head_rd_addr_i;
  logic [XLEN-1:0]      head_rd_data_i;
  logic                 head_regf_we_i;
  logic                 head_is_store_i;
  logic                 head_mispred_i;
  logic [XLEN-1:0]      head_pc_new_i;
  logic                 st_ack_i;

  logic                 dequeue_o;
  logic                 regf_we_o;
  logic [4:0]           regf_rd_addr_o;
  logic [XLEN-1:0]      regf_rd_data_o;
  logic [ROB_IDX_W-1:0] rat_clr_idx_o;
  logic                 st_req_o;
  logic                 flush_o;
  logic [XLEN-1:0]      redirect_pc_o;

  modport master (
    output head_valid_i, head_done_i, head_pc_i, head_rob_idx_i, head_rd_addr_i,
           head_rd_data_i, head_regf_we_i, head_is_store_i, head_mispred_i,
           head_pc_new_i, st_ack_i,
    input  dequeue_o, regf_we_o, regf_rd_addr_o, regf_rd_data_o, rat_clr_idx_o,
           st_req_o, flush_o, redirect_pc_o
  );

  modport slave (
    input  head_valid_i, head_done_i, head_pc_i, head_rob_idx_i, head_rd_addr_i,
           head_rd_data_i, head_regf_we_i, head_is_store_i, head_mispred_i,
           head_pc_new_i, st_ack_i,
    output dequeue_o, regf_we_o, regf_rd_addr_o, regf_rd_data_o, rat_clr_idx_o,
           st_req_o, flush_o, redirect_pc_o
  );
endinterface

// File: rtl/commit_unit.sv
// Purpose : in-order retire of the ROB head, one instruction per cycle; stores wait for ack, mispredicts flush.
// Latency : non-store retires combinationally; store retires on the ack cycle (>= 2 cycles); flush 1 cycle after.
// Backpressure: no retire while waiting for st_ack_i or during the flush cycle.
// Ports:
//   clk, rst        - clock, asynchronous active-high reset
//   cif (slave)     - ROB head entry in; dequeue / regfile write / RAT clear / store req / flush out
//   retire_count_o  - retired instruction count
//   flush_count_o   - flushes issued
// Config: define COMMIT_PERF_EN to implement the two counters; otherwise they are tied to 0.
module commit_unit #(
  parameter int XLEN      = 32,
  parameter int ROB_DEPTH = 32
) (
  input  logic        clk,
  input  logic        rst,
  commit_if.slave     cif,
  output logic [31:0] retire_count_o,
  output logic [31:0] flush_count_o
);
  localparam int ROB_IDX_W = $clog2(ROB_DEPTH);

  typedef enum logic [1:0] {RUN, STORE_WAIT, FLUSH} state_t;

  state_t state, state_nxt;
  logic   head_ready;
  logic   retire_alu;
  logic   retire_st;

  assign head_ready = cif.head_valid_i & cif.head_done_i;
  assign retire_alu = (state == RUN) & head_ready & ~cif.head_is_store_i;
  assign retire_st  = (state == STORE_WAIT) & cif.st_ack_i;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= RUN;
    else     state <= state_nxt;
  end

  // Next-state logic; mispredict on a store is ignored because the store branch wins.
  always_comb begin
    state_nxt = state;
    case (state)
      RUN: begin
        if (head_ready & cif.head_is_store_i)  state_nxt = STORE_WAIT;
        else if (head_ready & cif.head_mispred_i) state_nxt = FLUSH;
      end
      STORE_WAIT: if (cif.st_ack_i) state_nxt = RUN;
      FLUSH:      state_nxt = RUN;
      default:    state_nxt = RUN;
    endcase
  end

  // Combinational commit strobes, forced low while in reset.
  always_comb begin
    cif.dequeue_o      = 1'b0;
    cif.regf_we_o      = 1'b0;
    cif.regf_rd_addr_o = '0;
    cif.regf_rd_data_o = '0;
    cif.rat_clr_idx_o  = '0;
    if (!rst) begin
      cif.dequeue_o = retire_alu | retire_st;
      if (retire_alu) begin
        // x0 retires without a write
        cif.regf_we_o      = cif.head_regf_we_i & (cif.head_rd_addr_i != 5'd0);
        cif.regf_rd_addr_o = cif.head_rd_addr_i;
        cif.regf_rd_data_o = cif.head_rd_data_i;
      end
      if (retire_alu | retire_st) cif.rat_clr_idx_o = cif.head_rob_idx_i;
    end
  end

  // Store request and flush pulse are decoded straight from the state register,
  // so reset drops them asynchronously.
  assign cif.st_req_o = (state == STORE_WAIT);
  assign cif.flush_o  = (state == FLUSH);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                  cif.redirect_pc_o <= '0;
    else if (retire_alu & cif.head_mispred_i) cif.redirect_pc_o <= cif.head_pc_new_i;
  end

`ifdef COMMIT_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retire_count_o <= '0;
      flush_count_o  <= '0;
    end else begin
      if (cif.dequeue_o) retire_count_o <= retire_count_o + 32'd1;
      if (cif.flush_o)   flush_count_o  <= flush_count_o + 32'd1;
    end
  end
`else
  assign retire_count_o = '0;
  assign flush_count_o  = '0;
`endif

endmodule
